// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Perf counters are built only with `FETCH_PERF_EN defined.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [5:0] OPC_BEQ = 6'b000100;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of fetch entries with synchronous flush.
// Head is read straight from storage so outputs are register-driven.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  fetch_entry_t           entry_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_entry_t           head_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + AW'(1);
            if (pop_i)  rptr_d = rptr_q + AW'(1);
            unique case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (push_i && !flush_i) mem_q[wptr_q] <= entry_i;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: PC, imem drive, prefetch queue, valid/ready to decode.
// `FETCH_PERF_EN adds saturating fetch/stall/flush counters.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic          push, pop, empty;
    logic [CW-1:0] count;
    fetch_entry_t  head, entry;

    assign pop   = out_valid & out_ready;
    assign push  = fetch_en & ~redirect_valid
                 & ((count < CW'(DEPTH)) | pop);
    assign entry = '{pc: pc_q, instr: imem_rdata};

    // Redirect beats any sequential advance.
    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            redirect_valid: pc_d = {redirect_pc[31:2], 2'b00};
            push:           pc_d = pc_q + 32'(INSTR_BYTES);
            default:        pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .entry_i (entry),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .head_o  (head),
        .empty_o (empty),
        .count_o (count)
    );

    assign imem_addr    = pc_q;
    assign out_valid    = ~empty;
    assign out_pc       = head.pc;
    assign out_instr    = head.instr;
    assign out_pc_plus4 = head.pc + 32'(INSTR_BYTES);

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push)
                fetch_cnt_q <= sat_inc(fetch_cnt_q);
            if (out_valid && !out_ready)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (redirect_valid)
                flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: queue-based reference model plus
// directed checks on fill, redirect, wrap and async reset.
module tb_fetch_prefetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0;
    localparam logic [31:0] XMASK = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr, out_pc, out_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [63:0] mq[$];
    logic [31:0] mpc = RPC;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ XMASK;

    fetch_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = RPC;
    endtask

    task automatic model_step();
        bit pop, push;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pop  = (mq.size() > 0) && out_ready;
        push = fetch_en && !redirect_valid
             && ((mq.size() < DEPTH) || pop);
        if (redirect_valid) begin
            mq.delete();
            mpc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({mpc, mpc ^ XMASK});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        chk("m_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
        chk("m_imem_addr", imem_addr, mpc);
        if (mq.size() > 0) begin
            chk("m_out_pc", out_pc, mq[0][63:32]);
            chk("m_out_instr", out_instr, mq[0][31:0]);
            chk("m_out_pc_plus4", out_pc_plus4, mq[0][63:32] + 32'd4);
        end
    end

    initial begin
        model_reset();
        repeat (3) cyc();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_imem_addr", imem_addr, RPC);

        rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        cyc();
        chk("lat_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_pc0", out_pc, 32'h0);
        chk("lat_instr0", out_instr, 32'h1357_9BDF);
        cyc();
        chk("seq_pc4", out_pc, 32'h4);
        chk("seq_plus4", out_pc_plus4, 32'h8);
        cyc();
        chk("seq_pc8", out_pc, 32'h8);

        out_ready = 1'b0;
        repeat (5) cyc();
        chk("full_addr", imem_addr, 32'h10);
        chk("full_head", out_pc, 32'h8);

        out_ready = 1'b1;
        repeat (4) cyc();
        chk("flow_head", out_pc, 32'h18);
        chk("flow_addr", imem_addr, 32'h20);

        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        cyc();
        redirect_valid = 1'b0;
        chk("redir_valid", {31'b0, out_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        cyc();
        chk("redir_pc0", out_pc, 32'h100);
        cyc();
        chk("redir_pc1", out_pc, 32'h104);

        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cyc();
        redirect_pc = 32'h303;
        cyc();
        redirect_valid = 1'b0;
        chk("b2b_addr", imem_addr, 32'h300);
        chk("b2b_valid", {31'b0, out_valid}, 32'd0);

        cyc();
        cyc();
        fetch_en = 1'b0; out_ready = 1'b0;
        repeat (3) cyc();
        chk("frz_head", out_pc, 32'h304);
        chk("frz_addr", imem_addr, 32'h308);
        out_ready = 1'b1;
        repeat (2) cyc();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_addr", imem_addr, 32'h308);
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        cyc();
        redirect_valid = 1'b0;
        chk("frz_redir_addr", imem_addr, 32'h400);

        fetch_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cyc();
        redirect_valid = 1'b0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", out_pc_plus4, 32'h0);
        chk("wrap_addr1", imem_addr, 32'h0);

        for (int i = 0; i < 120; i++) begin
            out_ready      = (i % 3) != 0;
            fetch_en       = (i % 7) != 6;
            redirect_valid = (i % 23) == 11;
            redirect_pc    = i * 32'h44 + 32'h1;
            cyc();
        end
        redirect_valid = 1'b0;
        fetch_en = 1'b1; out_ready = 1'b0;
        repeat (3) cyc();

        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_addr", imem_addr, RPC);
        cyc();
        cyc();
        rst_n = 1'b1; out_ready = 1'b1;
        cyc();
        chk("rel_valid", {31'b0, out_valid}, 32'd1);
        chk("rel_pc", out_pc, RPC);
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
